// File: rtl/fbna_pool_pkg.sv
// rtl/fbna_pool_pkg.sv - shared widths, FSM state and FIFO word layout for the ofmap pooler
package fbna_pool_pkg;

    localparam int PACK_W = 8;
    localparam int CNT_W  = 4;

    typedef enum logic {
        S_EVEN = 1'b0,
        S_ODD  = 1'b1
    } state_e;

    typedef struct packed {
        logic              last;
        logic [CNT_W-1:0]  count;
        logic [PACK_W-1:0] data;
    } word_t;

endpackage

// File: rtl/fbna_pool_fifo.sv
// rtl/fbna_pool_fifo.sv - synchronous word FIFO; a push while full is taken only if a pop frees a slot
module fbna_pool_fifo
    import fbna_pool_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  push,
    input  word_t push_data,
    output logic  full,
    input  logic  pop,
    output logic  empty,
    output word_t head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    word_t          mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    cnt_q, cnt_d;
    logic           do_push;
    logic           do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == FULL_CNT);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem_q[rd_ptr_q];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + {{AW{1'b0}}, 1'b1};
            2'b01:   cnt_d = cnt_q - {{AW{1'b0}}, 1'b1};
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/fbna_ofmap_pool.sv
// rtl/fbna_ofmap_pool.sv - 2x2 binary OR-pooling of PBC columns, LSB-first packing into a dropping FIFO
// Optional sticky drop flag port ovf under FBNA_POOL_OVF_EN.
module fbna_ofmap_pool
    import fbna_pool_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [1:0]  in_ofmap,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic [3:0]  out_count,
    output logic        out_last
`ifdef FBNA_POOL_OVF_EN
    ,
    output logic        ovf
`endif
);

    state_e             state_q, state_d;
    logic               hold_q, hold_d;
    logic [PACK_W-1:0]  pack_reg_q, pack_reg_d;
    logic [CNT_W-1:0]   pack_cnt_q, pack_cnt_d;
    logic               col_or;
    logic               emit;
    logic               emit_bit;
    logic [PACK_W-1:0]  merged;
    logic               push;
    word_t              push_word;
    logic               full;
    logic               empty;
    logic               pop;
    word_t              head;

    assign col_or = |in_ofmap;
    assign merged = pack_reg_q | ({{(PACK_W-1){1'b0}}, emit_bit} << pack_cnt_q);

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        pack_reg_d = pack_reg_q;
        pack_cnt_d = pack_cnt_q;
        emit       = 1'b0;
        emit_bit   = 1'b0;
        push       = 1'b0;
        push_word  = '0;
        if (in_valid) begin
            case (state_q)
                S_EVEN: begin
                    if (in_last) begin
                        // odd trailing column is pooled on its own
                        emit     = 1'b1;
                        emit_bit = col_or;
                    end else begin
                        hold_d  = col_or;
                        state_d = S_ODD;
                    end
                end
                default: begin
                    emit     = 1'b1;
                    emit_bit = hold_q | col_or;
                    state_d  = S_EVEN;
                end
            endcase
        end
        if (emit) begin
            if ((pack_cnt_q == CNT_W'(PACK_W-1)) || in_last) begin
                push            = 1'b1;
                push_word.data  = merged;
                push_word.count = pack_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                push_word.last  = in_last;
                pack_reg_d      = '0;
                pack_cnt_d      = '0;
            end else begin
                pack_reg_d = merged;
                pack_cnt_d = pack_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_EVEN;
            hold_q     <= 1'b0;
            pack_reg_q <= '0;
            pack_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            pack_reg_q <= pack_reg_d;
            pack_cnt_q <= pack_cnt_d;
        end
    end

    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;
    assign out_data  = head.data;
    assign out_count = head.count;
    assign out_last  = head.last;

    fbna_pool_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_word),
        .full      (full),
        .pop       (pop),
        .empty     (empty),
        .head      (head)
    );

`ifdef FBNA_POOL_OVF_EN
    logic ovf_q, ovf_d;

    assign ovf_d = ovf_q | (push & full & ~pop);
    assign ovf   = ovf_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
`endif

endmodule

// File: tb/tb_fbna_ofmap_pool.sv
// tb/tb_fbna_ofmap_pool.sv - scoreboard bench for fbna_ofmap_pool (ovf checks under FBNA_POOL_OVF_EN)
module tb_fbna_ofmap_pool;

    logic       clock;
    logic       reset;
    logic       in_valid;
    logic [1:0] in_ofmap;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [3:0] out_count;
    logic       out_last;
`ifdef FBNA_POOL_OVF_EN
    logic       ovf;
`endif

    int checks = 0;
    int errors = 0;
    logic [12:0] exp_q[$];

    fbna_ofmap_pool #(
        .FIFO_DEPTH (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ofmap  (in_ofmap),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_last  (out_last)
`ifdef FBNA_POOL_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a handshake seen at the negedge completes at the next posedge.
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", {19'd0, out_last, out_count, out_data}, 32'hDEAD);
            end else begin
                check("word", {19'd0, out_last, out_count, out_data}, {19'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic col(input logic [1:0] v, input logic l);
        in_valid = 1'b1;
        in_ofmap = v;
        in_last  = l;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_ofmap = 2'b00;
        in_last  = 1'b0;
    endtask

    task automatic expect_word(input logic l, input logic [3:0] c, input logic [7:0] d);
        exp_q.push_back({l, c, d});
    endtask

    // Eight column pairs producing data d; pair bit 1 uses top-row pixel only.
    task automatic send_word(input logic [7:0] d);
        for (int b = 0; b < 8; b++) begin
            col(d[b] ? 2'b10 : 2'b00, 1'b0);
            col(2'b00, 1'b0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clock);
            #1;
            if (exp_q.size() == 0) break;
        end
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_empty_after"}, {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_ofmap  = 2'b00;
        in_last   = 1'b0;
        out_ready = 1'b0;
        do_reset();
        check("rst_valid", {31'd0, out_valid}, 0);
        check("rst_data",  {24'd0, out_data}, 0);
        check("rst_count", {28'd0, out_count}, 0);
        check("rst_last",  {31'd0, out_last}, 0);
`ifdef FBNA_POOL_OVF_EN
        check("rst_ovf", {31'd0, ovf}, 0);
`endif

        // 16 columns 01,00 -> 8'hFF, count 8, one cycle after the last column
        out_ready = 1'b1;
        expect_word(1'b0, 4'd8, 8'hFF);
        for (int i = 0; i < 15; i++) col((i % 2 == 0) ? 2'b01 : 2'b00, 1'b0);
        check("lat_before", {31'd0, out_valid}, 0);
        col(2'b00, 1'b0);
        check("lat_after", {31'd0, out_valid}, 1);
        drain("t1");

        // in_last on 8th column -> 4-bit word 1010
        out_ready = 1'b1;
        expect_word(1'b1, 4'd4, 8'b0000_1010);
        col(2'b00, 0); col(2'b00, 0); col(2'b10, 0); col(2'b00, 0);
        col(2'b00, 0); col(2'b00, 0); col(2'b00, 0); col(2'b11, 1);
        drain("t2");

        // odd trailing column pooled alone
        out_ready = 1'b1;
        expect_word(1'b1, 4'd2, 8'b0000_0010);
        col(2'b00, 0); col(2'b00, 0); col(2'b01, 1);
        drain("t3");

        // overflow: 160 columns of 11 -> 10 words, 4 kept
        out_ready = 1'b0;
        for (int w = 0; w < 4; w++) expect_word(1'b0, 4'd8, 8'hFF);
        for (int i = 0; i < 160; i++) begin
`ifdef FBNA_POOL_OVF_EN
            if (i == 79) check("ovf_before_drop", {31'd0, ovf}, 0);
`endif
            col(2'b11, 1'b0);
`ifdef FBNA_POOL_OVF_EN
            if (i == 79) check("ovf_at_drop", {31'd0, ovf}, 1);
`endif
        end
        check("ovf_hold_valid", {31'd0, out_valid}, 1);
        check("ovf_hold_data", {24'd0, out_data}, 32'hFF);
        drain("t4");

        // full FIFO, push coincides with pop
        do_reset();
        for (int w = 0; w < 4; w++) begin
            expect_word(1'b0, 4'd8, 8'hFF);
            send_word(8'hFF);
        end
        expect_word(1'b0, 4'd8, 8'hA5);
        for (int b = 0; b < 7; b++) begin
            col(b[0] == 1'b0 && b != 6 && b != 2 && b != 4 ? 2'b10 : (b == 2 || b == 5) ? 2'b10 : 2'b00, 1'b0);
            col(2'b00, 1'b0);
        end
        col(2'b00, 1'b0);
        out_ready = 1'b1;
        col(2'b10, 1'b0);
        out_ready = 1'b0;
`ifdef FBNA_POOL_OVF_EN
        check("ovf_push_pop", {31'd0, ovf}, 0);
`endif
        check("pp_valid", {31'd0, out_valid}, 1);
        drain("t5");

        // reset mid-row discards hold and the partial word
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) col(2'b11, 1'b0);
        do_reset();
        check("mid_rst_valid", {31'd0, out_valid}, 0);
`ifdef FBNA_POOL_OVF_EN
        check("mid_rst_ovf", {31'd0, ovf}, 0);
`endif
        out_ready = 1'b1;
        expect_word(1'b0, 4'd8, 8'h00);
        for (int i = 0; i < 16; i++) col(2'b00, 1'b0);
        drain("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
